// File: rtl/fish_sprite_ctrl.sv
// Fish sprite controller: per-frame horizontal motion with edge bounce, and a
// two-stage per-pixel pipeline sharing one 16x32 sprite ROM among NUM_FISH fish.
module fish_sprite_ctrl #(
    parameter int          NUM_FISH  = 2,
    parameter int          H_MAX     = 640,
    parameter int          SPEED     = 1,
    parameter int          X0        = 100,
    parameter int          X_SPACING = 64,
    parameter int          Y0        = 200,
    parameter int          Y_SPACING = 40,
    parameter logic [11:0] KEY_COLOR = 12'h0F0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      frame_tick,
    input  logic                      video_on,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    output logic [3:0]                rom_row,
    output logic [4:0]                rom_col,
    input  logic [11:0]               rom_data,
    output logic [11:0]               rgb_out,
    output logic                      fish_on,
    output logic                      busy,
    output logic [10*NUM_FISH-1:0]    fish_x,
    output logic [NUM_FISH-1:0]       fish_dir
);

    localparam int              IW       = (NUM_FISH > 1) ? $clog2(NUM_FISH) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_FISH - 1);
    localparam logic [10:0]     X_LIM    = 11'(H_MAX - 32);
    localparam logic [10:0]     STEP     = 11'(SPEED);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    function automatic logic [9:0] init_x(input int k);
        return 10'(X0 + k * X_SPACING);
    endfunction

    function automatic logic [10:0] fish_y(input int k);
        return 11'(Y0 + k * Y_SPACING);
    endfunction

    function automatic logic [3:0] fish_y_lo(input int k);
        logic [10:0] fy;
        fy = fish_y(k);
        return fy[3:0];
    endfunction

    // Returns {new_dir, new_x}; 11-bit math so neither edge test can wrap.
    function automatic logic [10:0] move(input logic [9:0] px, input logic d);
        logic [10:0] ext;
        logic [10:0] nxt;
        ext = {1'b0, px};
        if (d) begin
            nxt = ext + STEP;
            if (nxt >= X_LIM) begin
                return {1'b0, X_LIM[9:0]};
            end else begin
                return {1'b1, nxt[9:0]};
            end
        end else begin
            if (ext < STEP) begin
                return {1'b1, 10'd0};
            end else begin
                nxt = ext - STEP;
                return {1'b0, nxt[9:0]};
            end
        end
    endfunction

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic                  r_busy;
    logic [9:0]            r_x [NUM_FISH];
    logic [NUM_FISH-1:0]   r_dir;
    logic                  r_hit_d1;
    logic                  r_fish_on;
    logic [11:0]           r_rgb;

    logic [NUM_FISH-1:0]   w_hit;
    logic                  w_any;
    logic [IW-1:0]         w_win;
    logic [4:0]            w_dx;
    logic [3:0]            w_dy;
    logic                  w_wdir;
    logic                  w_fish_on_next;

    genvar gk;
    generate
        for (gk = 0; gk < NUM_FISH; gk++) begin : g_fish
            localparam logic [10:0] FY = fish_y(gk);
            assign w_hit[gk] = video_on
                && ({1'b0, x} >= {1'b0, r_x[gk]})
                && ({1'b0, x} <  ({1'b0, r_x[gk]} + 11'd32))
                && ({1'b0, y} >= FY)
                && ({1'b0, y} <  (FY + 11'd16));
            assign fish_x[10*gk +: 10] = r_x[gk];
        end
    endgenerate

    // Priority pick: scanning downwards leaves the lowest-index hit as winner.
    always_comb begin
        w_win = '0;
        for (int k = NUM_FISH - 1; k >= 0; k--) begin
            w_win = w_hit[k] ? IW'(k) : w_win;
        end
    end

    assign w_any          = |w_hit;
    assign w_dx           = x[4:0] - r_x[w_win][4:0];
    assign w_dy           = y[3:0] - fish_y_lo(int'(w_win));
    assign w_wdir         = r_dir[w_win];
    assign rom_row        = w_any ? w_dy : 4'd0;
    assign rom_col        = w_any ? (w_wdir ? (5'd31 - w_dx) : w_dx) : 5'd0;
    assign w_fish_on_next = r_hit_d1 && (rom_data != KEY_COLOR);

    // Motion FSM: one fish updated per cycle after an accepted frame tick.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_dir   <= '1;
            for (int k = 0; k < NUM_FISH; k++) begin
                r_x[k] <= init_x(k);
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_tick && enable) begin
                        r_state <= ST_UPDATE;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    {r_dir[r_idx], r_x[r_idx]} <= move(r_x[r_idx], r_dir[r_idx]);
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pixel pipeline: hit flag aligned with ROM data, then keyed colour out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hit_d1  <= 1'b0;
            r_fish_on <= 1'b0;
            r_rgb     <= 12'd0;
        end else begin
            r_hit_d1  <= w_any;
            r_fish_on <= w_fish_on_next;
            r_rgb     <= w_fish_on_next ? rom_data : 12'd0;
        end
    end

    assign busy     = r_busy;
    assign fish_dir = r_dir;
    assign fish_on  = r_fish_on;
    assign rgb_out  = r_rgb;

endmodule

// File: tb/tb_fish_sprite_ctrl.sv
// Directed testbench for fish_sprite_ctrl: four instances with different
// parameters share the pixel/tick stimulus and each has its own motion enable.
module tb_fish_sprite_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, frame_tick, video_on;
    logic [9:0]  x, y;
    logic        en_a, en_b, en_c, en_d;
    logic [11:0] rom_val, rom_q;

    always @(posedge clk) rom_q <= rom_val;

    logic [3:0]  rr_a, rr_b, rr_c, rr_d;
    logic [4:0]  rc_a, rc_b, rc_c, rc_d;
    logic [11:0] rgb_a, rgb_b, rgb_c, rgb_d;
    logic        on_a, on_b, on_c, on_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic [19:0] fx_a, fx_b, fx_c;
    logic [9:0]  fx_d;
    logic [1:0]  fd_a, fd_b, fd_c;
    logic [0:0]  fd_d;

    int n_cmp = 0;
    int n_err = 0;

    fish_sprite_ctrl u_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .frame_tick(frame_tick),
        .video_on(video_on), .x(x), .y(y), .rom_row(rr_a), .rom_col(rc_a),
        .rom_data(rom_q), .rgb_out(rgb_a), .fish_on(on_a), .busy(busy_a),
        .fish_x(fx_a), .fish_dir(fd_a));

    fish_sprite_ctrl #(.SPEED(4)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .frame_tick(frame_tick),
        .video_on(video_on), .x(x), .y(y), .rom_row(rr_b), .rom_col(rc_b),
        .rom_data(rom_q), .rgb_out(rgb_b), .fish_on(on_b), .busy(busy_b),
        .fish_x(fx_b), .fish_dir(fd_b));

    fish_sprite_ctrl #(.X_SPACING(16), .Y_SPACING(0)) u_c (
        .clk(clk), .reset_n(reset_n), .enable(en_c), .frame_tick(frame_tick),
        .video_on(video_on), .x(x), .y(y), .rom_row(rr_c), .rom_col(rc_c),
        .rom_data(rom_q), .rgb_out(rgb_c), .fish_on(on_c), .busy(busy_c),
        .fish_x(fx_c), .fish_dir(fd_c));

    fish_sprite_ctrl #(.NUM_FISH(1), .H_MAX(66), .SPEED(4), .X0(30)) u_d (
        .clk(clk), .reset_n(reset_n), .enable(en_d), .frame_tick(frame_tick),
        .video_on(video_on), .x(x), .y(y), .rom_row(rr_d), .rom_col(rc_d),
        .rom_data(rom_q), .rgb_out(rgb_d), .fish_on(on_d), .busy(busy_d),
        .fish_x(fx_d), .fish_dir(fd_d));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        #1;
        n_cmp++; if (fx_a !== {10'd164, 10'd100}) begin n_err++; $display("FAIL reset_fish_x: actual %h required %h", fx_a, {10'd164, 10'd100}); end
        n_cmp++; if (fd_a !== 2'b11) begin n_err++; $display("FAIL reset_fish_dir: actual %b required 11", fd_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: actual %b required 0", busy_a); end
        n_cmp++; if (rgb_a !== 12'h000) begin n_err++; $display("FAIL reset_rgb: actual %h required 000", rgb_a); end
        n_cmp++; if (on_a !== 1'b0) begin n_err++; $display("FAIL reset_fish_on: actual %b required 0", on_a); end
    endtask

    task automatic test_pixel();
        video_on = 1'b1; x = 10'd100; y = 10'd200; rom_val = 12'hD74;
        #1;
        n_cmp++; if (rr_a !== 4'd0) begin n_err++; $display("FAIL pix_row: actual %0d required 0", rr_a); end
        n_cmp++; if (rc_a !== 5'd31) begin n_err++; $display("FAIL pix_col: actual %0d required 31", rc_a); end
        step(2);
        n_cmp++; if (rgb_a !== 12'hD74) begin n_err++; $display("FAIL pix_rgb: actual %h required D74", rgb_a); end
        n_cmp++; if (on_a !== 1'b1) begin n_err++; $display("FAIL pix_on: actual %b required 1", on_a); end
        x = 10'd110; y = 10'd205;
        #1;
        n_cmp++; if (rr_a !== 4'd5) begin n_err++; $display("FAIL pix_row_mid: actual %0d required 5", rr_a); end
        n_cmp++; if (rc_a !== 5'd21) begin n_err++; $display("FAIL pix_col_mid: actual %0d required 21", rc_a); end
        x = 10'd164; y = 10'd240;
        #1;
        n_cmp++; if (rr_a !== 4'd0 || rc_a !== 5'd31) begin n_err++; $display("FAIL pix_fish1: actual row %0d col %0d required row 0 col 31", rr_a, rc_a); end
    endtask

    task automatic test_transparency();
        rom_val = 12'h0F0; x = 10'd100; y = 10'd200;
        step(2);
        n_cmp++; if (on_a !== 1'b0) begin n_err++; $display("FAIL key_on: actual %b required 0", on_a); end
        n_cmp++; if (rgb_a !== 12'h000) begin n_err++; $display("FAIL key_rgb: actual %h required 000", rgb_a); end
        rom_val = 12'hD74; x = 10'd131; y = 10'd215;
        #1;
        n_cmp++; if (rr_a !== 4'd15 || rc_a !== 5'd0) begin n_err++; $display("FAIL edge_last: actual row %0d col %0d required row 15 col 0", rr_a, rc_a); end
        x = 10'd132;
        #1;
        n_cmp++; if (rr_a !== 4'd0 || rc_a !== 5'd0) begin n_err++; $display("FAIL edge_out: actual row %0d col %0d required 0/0", rr_a, rc_a); end
        step(2);
        n_cmp++; if (on_a !== 1'b0 || rgb_a !== 12'h000) begin n_err++; $display("FAIL edge_out_pix: actual on %b rgb %h required 0/000", on_a, rgb_a); end
        video_on = 1'b0; x = 10'd100; y = 10'd200;
        #1;
        n_cmp++; if (rr_a !== 4'd0 || rc_a !== 5'd0) begin n_err++; $display("FAIL blank_addr: actual row %0d col %0d required 0/0", rr_a, rc_a); end
        step(2);
        n_cmp++; if (on_a !== 1'b0 || rgb_a !== 12'h000) begin n_err++; $display("FAIL blank_pix: actual on %b rgb %h required 0/000", on_a, rgb_a); end
    endtask

    task automatic test_overlap();
        video_on = 1'b1; y = 10'd200; x = 10'd120;
        #1;
        n_cmp++; if (rc_c !== 5'd11 || rr_c !== 4'd0) begin n_err++; $display("FAIL overlap_fish0: actual col %0d row %0d required 11/0", rc_c, rr_c); end
        x = 10'd140;
        #1;
        n_cmp++; if (rc_c !== 5'd7) begin n_err++; $display("FAIL overlap_fish1: actual col %0d required 7", rc_c); end
        video_on = 1'b0;
        step(1);
    endtask

    task automatic test_enable_off();
        en_a = 1'b0;
        pulse_tick();
        n_cmp++; if (fx_a !== {10'd164, 10'd100} || busy_a !== 1'b0) begin n_err++; $display("FAIL enable_off: actual x %h busy %b required %h/0", fx_a, busy_a, {10'd164, 10'd100}); end
    endtask

    task automatic test_back_to_back();
        en_a = 1'b1;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL busy_c1: actual %b required 1", busy_a); end
        step(1);
        frame_tick = 1'b1;
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL busy_c2: actual %b required 1", busy_a); end
        step(1);
        frame_tick = 1'b0;
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL busy_c3: actual %b required 0", busy_a); end
        step(3);
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL busy_noqueue: actual %b required 0", busy_a); end
        n_cmp++; if (fx_a !== {10'd165, 10'd101} || fd_a !== 2'b11) begin n_err++; $display("FAIL move_once: actual x %h dir %b required %h/11", fx_a, fd_a, {10'd165, 10'd101}); end
        en_a = 1'b0;
    endtask

    task automatic test_reset_mid_update();
        en_a = 1'b1;
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
        step(1);
        n_cmp++; if (fx_a[9:0] !== 10'd102 || busy_a !== 1'b1) begin n_err++; $display("FAIL mid_update: actual x0 %0d busy %b required 102/1", fx_a[9:0], busy_a); end
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy: actual %b required 0", busy_a); end
        n_cmp++; if (fx_a !== {10'd164, 10'd100} || fd_a !== 2'b11) begin n_err++; $display("FAIL mid_reset_pos: actual x %h dir %b required %h/11", fx_a, fd_a, {10'd164, 10'd100}); end
        step(2);
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid_reset_idle: actual %b required 0", busy_a); end
        en_a = 1'b0;
    endtask

    task automatic test_bounce_right();
        en_b = 1'b1;
        repeat (126) pulse_tick();
        n_cmp++; if (fx_b[9:0] !== 10'd604 || fd_b[0] !== 1'b1) begin n_err++; $display("FAIL bounce_preset: actual x %0d dir %b required 604/1", fx_b[9:0], fd_b[0]); end
        pulse_tick();
        n_cmp++; if (fx_b[9:0] !== 10'd608 || fd_b[0] !== 1'b0) begin n_err++; $display("FAIL bounce_right: actual x %0d dir %b required 608/0", fx_b[9:0], fd_b[0]); end
        pulse_tick();
        n_cmp++; if (fx_b[9:0] !== 10'd604 || fd_b[0] !== 1'b0) begin n_err++; $display("FAIL bounce_return: actual x %0d dir %b required 604/0", fx_b[9:0], fd_b[0]); end
        en_b = 1'b0;
    endtask

    task automatic test_bounce_left();
        en_d = 1'b1;
        pulse_tick();
        n_cmp++; if (fx_d !== 10'd34 || fd_d !== 1'b0) begin n_err++; $display("FAIL left_turn: actual x %0d dir %b required 34/0", fx_d, fd_d); end
        repeat (8) pulse_tick();
        n_cmp++; if (fx_d !== 10'd2 || fd_d !== 1'b0) begin n_err++; $display("FAIL left_preset: actual x %0d dir %b required 2/0", fx_d, fd_d); end
        pulse_tick();
        n_cmp++; if (fx_d !== 10'd0 || fd_d !== 1'b1) begin n_err++; $display("FAIL bounce_left: actual x %0d dir %b required 0/1", fx_d, fd_d); end
        pulse_tick();
        n_cmp++; if (fx_d !== 10'd4 || fd_d !== 1'b1) begin n_err++; $display("FAIL left_depart: actual x %0d dir %b required 4/1", fx_d, fd_d); end
        en_d = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; frame_tick = 1'b0; video_on = 1'b0;
        x = 10'd0; y = 10'd0; rom_val = 12'h000;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
        test_reset();
        test_pixel();
        test_transparency();
        test_overlap();
        test_enable_off();
        test_back_to_back();
        test_reset_mid_update();
        test_bounce_right();
        test_bounce_left();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/fish_sprite_ctrl.md
Name: fish_sprite_ctrl

Overview:
- Controller that shares one 16x32 fish sprite ROM (1-cycle registered-address ROM, 12-bit RGB out) among NUM_FISH on-screen fish.
- Per frame, walks a motion state machine that moves each fish horizontally, with edge bounce and facing flip.
- Per pixel, arbitrates which fish owns the current VGA pixel, generates the ROM row/col (mirrored when facing right), and drives keyed RGB to the pixel mux.
- Sits between the VGA sync generator and the top-level colour mux.

Parameters:
- NUM_FISH, 2, number of fish sharing the ROM (1..8).
- H_MAX, 640, visible screen width in pixels.
- SPEED, 1, pixels moved per frame_tick.
- X0, 100, fish 0 initial x.
- X_SPACING, 64, initial x offset between consecutive fish.
- Y0, 200, fish 0 y (fixed).
- Y_SPACING, 40, y offset between consecutive fish.
- KEY_COLOR, 12'h0F0, transparent colour in ROM data.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- enable  in  1  motion enable
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- video_on  in  1  pixel in visible area
- x  in  10  current pixel x
- y  in  10  current pixel y
- rom_row  out  4  sprite ROM row address
- rom_col  out  5  sprite ROM column address
- rom_data  in  12  sprite ROM colour, valid the cycle after address presented
- rgb_out  out  12  fish pixel colour, 0 when not fish_on
- fish_on  out  1  opaque fish pixel present
- busy  out  1  motion update in progress
- fish_x  out  10*NUM_FISH  packed fish x positions, fish k at bits [10k+9:10k]
- fish_dir  out  NUM_FISH  1 = moving right, 0 = moving left

Behaviour:
- Reset (reset_n=0 at clk edge):
  - fish k x = X0 + k*X_SPACING; dir = 1.
  - FSM = IDLE; idx = 0.
  - busy, fish_on, rgb_out and pipeline regs = 0.
  - Reset wins over any concurrent event, including mid-UPDATE.
- Fish geometry: fish k y = Y0 + k*Y_SPACING (constant). Fish k covers x in [fx, fx+31] and y in [fy, fy+15].
- Motion FSM, states IDLE and UPDATE:
  - IDLE -> UPDATE when frame_tick && enable; idx <= 0; busy = 1 while in UPDATE.
  - UPDATE: one fish per cycle (fish idx), then idx++. After fish NUM_FISH-1 -> IDLE. Total NUM_FISH cycles busy.
  - frame_tick while busy, or while enable=0: ignored, with no queuing.
- Per-fish position update:
  - dir=1: next = x+SPEED. If next >= H_MAX-32 then x <= H_MAX-32, dir <= 0; else x <= next.
  - dir=0: if x < SPEED then x <= 0, dir <= 1; else x <= x-SPEED.
  - All arithmetic is 11-bit unsigned to avoid wrap.
- Pixel arbitration, stage 0 (combinational from x, y, positions):
  - hit_k = video_on && x,y inside fish k box.
  - Lowest-index hit wins.
  - rom_row = y - fy[win]; rom_col = dx if dir=0, else 31-dx, where dx = x - fx[win].
  - No hit: rom_row = 0, rom_col = 0.
- Stage 1: hit_d1 <= any hit (registered); the ROM latches the address on the same edge; rom_data valid during stage 1.
- Stage 2 (registered):
  - fish_on <= hit_d1 && rom_data != KEY_COLOR.
  - rgb_out <= fish_on_next ? rom_data : 0.
- Latency: x/y/video_on to rgb_out/fish_on is 2 cycles.
- Positions changing during UPDATE may affect pixels in flight. This is acceptable because frame_tick occurs in vblank (video_on=0).

Test Plan:
- Reset defaults: reset_n=0 for 2 cycles, release. Required: fish_x = {164, 100}, fish_dir = 2'b11, busy = 0, rgb_out = 0, fish_on = 0.
- Pixel fetch: x=100, y=200, video_on=1, ROM model returns 12'hD74. Required: same cycle rom_row = 0, rom_col = 31; two cycles later rgb_out = 12'hD74, fish_on = 1.
- Transparency and blanking:
  - ROM returns 12'h0F0 -> fish_on = 0, rgb_out = 0.
  - video_on = 0 at x=100, y=200 -> rom_row/col = 0, fish_on = 0.
- Bounce with SPEED=4, fish0 preset by ticks to x=604, dir=1:
  - frame_tick -> x = 608, dir = 0.
  - Next tick -> x = 604.
  - Fish at x=2, dir=0: tick -> x = 0, dir = 1.
- Overlap priority with X_SPACING=16, Y_SPACING=0 (fish0 100..131, fish1 116..147), y=200:
  - x=120 -> rom_col = 11 (fish0).
  - x=140 -> rom_col = 7 (fish1).
- Control corner cases:
  - frame_tick with enable = 0 -> positions unchanged.
  - Second frame_tick while busy = 1 -> ignored; busy lasts exactly NUM_FISH cycles.
  - reset_n = 0 during UPDATE -> initial positions restored, busy = 0 next cycle.
